// File: rtl/seg_display_driver.sv
// Seven-segment display back end: syncs the digit select, drives anodes,
// cathodes and decimal point with tear-free commits and anti-ghost blanking.
module seg_display_driver #(
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [1:0]  digit_sel,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp_n,
    output logic        commit
);

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

    // {dp[3:0], nibble3, nibble2, nibble1, nibble0}
    logic [19:0] shadow;
    logic [19:0] display;
    logic [19:0] disp_next;
    logic        pending;

    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  s3;
    logic        change;

    logic [1:0]  cur_digit;
    logic [7:0]  blank_cnt;

    logic [3:0]  nib;
    logic        dp_bit;
    logic        lz_blank;
    logic [6:0]  seg;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] r;
        unique case (v)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    assign change = (s2 != s3);

    // The frame boundary is the synchronized transition onto digit 0
    assign commit = change && (s2 == 2'd0) && pending;

    // Value the newly selected digit decodes from, including a same-cycle commit
    assign disp_next = commit ? shadow : display;

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s1 <= 2'd0;
            s2 <= 2'd0;
            s3 <= 2'd0;
        end else begin
            s1 <= digit_sel;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Shadow capture and pending flag; a load in the commit cycle re-arms pending
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            shadow  <= 20'd0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= {dp_in, data_in};
            end
            if (commit) begin
                pending <= load;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Display register only moves at a frame boundary
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            display <= 20'd0;
        end else if (commit) begin
            display <= shadow;
        end
    end

    // Select nibble and decimal point of the digit being switched to
    always_comb begin
        nib    = disp_next[3:0];
        dp_bit = disp_next[16];
        unique case (s2)
            2'd0: begin
                nib    = disp_next[3:0];
                dp_bit = disp_next[16];
            end
            2'd1: begin
                nib    = disp_next[7:4];
                dp_bit = disp_next[17];
            end
            2'd2: begin
                nib    = disp_next[11:8];
                dp_bit = disp_next[18];
            end
            default: begin
                nib    = disp_next[15:12];
                dp_bit = disp_next[19];
            end
        endcase
    end

    // Leading-zero suppression: a digit blanks when it and all digits left of it are zero
    always_comb begin
        lz_blank = 1'b0;
        if (blank_lz) begin
            unique case (s2)
                2'd3: lz_blank = (disp_next[15:12] == 4'h0);
                2'd2: lz_blank = (disp_next[15:8] == 8'h00);
                2'd1: lz_blank = (disp_next[15:4] == 12'h000);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    assign seg = lz_blank ? 7'b1111111 : hex_to_seg(nib);

    // Digit change: latch segments, kill anodes, start blank interval
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cur_digit <= 2'd0;
            blank_cnt <= 8'd0;
            anode     <= 4'b1111;
            cathode   <= 7'b1111111;
            dp_n      <= 1'b1;
        end else if (change) begin
            cur_digit <= s2;
            blank_cnt <= BLANK_LOAD;
            anode     <= 4'b1111;
            cathode   <= seg;
            dp_n      <= ~dp_bit;
        end else if (blank_cnt != 8'd0) begin
            blank_cnt <= blank_cnt - 8'd1;
            if (blank_cnt == 8'd1) begin
                anode <= ~(4'b0001 << cur_digit);
            end
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: scan order, tear-free commit,
// leading-zero blanking, retriggered blanking and asynchronous reset.
module tb_seg_display_driver;

    logic        clock_in = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  digit_sel = 2'd0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp_n;
    logic        commit;

    int npass = 0;
    int ntot = 0;
    int commit_cnt = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_display_driver #(.BLANK_CYCLES(16)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .digit_sel(digit_sel),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .load     (load),
        .blank_lz (blank_lz),
        .anode    (anode),
        .cathode  (cathode),
        .dp_n     (dp_n),
        .commit   (commit)
    );

    always #20 clock_in = ~clock_in;

    // count commit pulses, sampled mid-cycle
    always @(negedge clock_in) begin
        if (commit === 1'b1) commit_cnt++;
    end

    // change digit_sel, then stop at the last edge before its anode may turn on
    task automatic drive_digit(input logic [1:0] d);
        @(negedge clock_in);
        digit_sel = d;
        repeat (18) @(posedge clock_in);
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clock_in);
        data_in = d;
        dp_in = p;
        load = 1'b1;
        @(negedge clock_in);
        load = 1'b0;
    endtask

    task automatic test_reset;
        #3 reset = 1'b1;
        #2;
        ntot++;
        if (anode !== 4'b1111) $display("FAIL rst_anode got %b want 1111", anode);
        else npass++;
        ntot++;
        if (cathode !== 7'b1111111) $display("FAIL rst_cathode got %b want 1111111", cathode);
        else npass++;
        ntot++;
        if (dp_n !== 1'b1 || commit !== 1'b0)
            $display("FAIL rst_dp_commit got dp_n=%b commit=%b want 1 0", dp_n, commit);
        else npass++;
        repeat (3) @(negedge clock_in);
        reset = 1'b0;
        repeat (6) @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b1111 || cathode !== 7'b1111111)
            $display("FAIL dark_after_reset got %b %b want 1111 1111111", anode, cathode);
        else npass++;
    endtask

    task automatic test_scan_no_load;
        logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int c0;
        c0 = commit_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_digit(seq[i]);
            ntot++;
            if (anode !== 4'b1111) $display("FAIL scan_pre%0d anode got %b want 1111", i, anode);
            else npass++;
            @(posedge clock_in);
            #1;
            ntot++;
            if (anode !== an_tab[seq[i]] || cathode !== 7'b1000000)
                $display("FAIL scan%0d got %b %b want %b 1000000",
                         i, anode, cathode, an_tab[seq[i]]);
            else npass++;
        end
        ntot++;
        if (commit_cnt !== c0) $display("FAIL scan_commit got %0d want %0d", commit_cnt, c0);
        else npass++;
    endtask

    task automatic test_load_commit;
        logic [1:0] seq [6] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [6:0] cth [6] = '{7'b1000000, 7'b1000000, 7'b0001110,
                                7'b0001000, 7'b0100100, 7'b1111001};
        logic       dpx [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int         cdl [6] = '{0, 0, 1, 1, 1, 1};
        int c0;
        drive_digit(2'd1);
        pulse_load(16'h12AF, 4'b0100);
        c0 = commit_cnt;
        for (int i = 0; i < 6; i++) begin
            drive_digit(seq[i]);
            @(posedge clock_in);
            #1;
            ntot++;
            if (anode !== an_tab[seq[i]] || cathode !== cth[i] || dp_n !== dpx[i])
                $display("FAIL load%0d got %b %b dp_n=%b want %b %b dp_n=%b",
                         i, anode, cathode, dp_n, an_tab[seq[i]], cth[i], dpx[i]);
            else npass++;
            ntot++;
            if (commit_cnt - c0 !== cdl[i])
                $display("FAIL load_commit%0d got %0d want %0d", i, commit_cnt - c0, cdl[i]);
            else npass++;
        end
    endtask

    task automatic test_lz;
        logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [6:0] c50 [4] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
        logic [6:0] c00 [4] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        blank_lz = 1'b1;
        pulse_load(16'h0050, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            drive_digit(seq[i]);
            @(posedge clock_in);
            #1;
            ntot++;
            if (anode !== an_tab[seq[i]] || cathode !== c50[i])
                $display("FAIL lz50_%0d got %b %b want %b %b",
                         i, anode, cathode, an_tab[seq[i]], c50[i]);
            else npass++;
        end
        pulse_load(16'h0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            drive_digit(seq[i]);
            @(posedge clock_in);
            #1;
            ntot++;
            if (anode !== an_tab[seq[i]] || cathode !== c00[i])
                $display("FAIL lz00_%0d got %b %b want %b %b",
                         i, anode, cathode, an_tab[seq[i]], c00[i]);
            else npass++;
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_load_at_commit;
        int c0;
        pulse_load(16'h1234, 4'b0000);
        c0 = commit_cnt;
        @(negedge clock_in);
        digit_sel = 2'd0;
        @(negedge clock_in);
        @(negedge clock_in);
        ntot++;
        if (commit !== 1'b1) $display("FAIL lac_commit got %b want 1", commit);
        else npass++;
        data_in = 16'h5678;
        load = 1'b1;
        @(negedge clock_in);
        load = 1'b0;
        repeat (15) @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b1111) $display("FAIL lac_pre anode got %b want 1111", anode);
        else npass++;
        @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b1110 || cathode !== 7'b0011001)
            $display("FAIL lac_old got %b %b want 1110 0011001", anode, cathode);
        else npass++;
        drive_digit(2'd1);
        @(posedge clock_in);
        #1;
        ntot++;
        if (cathode !== 7'b0110000) $display("FAIL lac_d1 got %b want 0110000", cathode);
        else npass++;
        drive_digit(2'd2);
        drive_digit(2'd3);
        ntot++;
        if (commit_cnt !== c0 + 1)
            $display("FAIL lac_cnt1 got %0d want %0d", commit_cnt, c0 + 1);
        else npass++;
        drive_digit(2'd0);
        @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b1110 || cathode !== 7'b0000000)
            $display("FAIL lac_new got %b %b want 1110 0000000", anode, cathode);
        else npass++;
        ntot++;
        if (commit_cnt !== c0 + 2)
            $display("FAIL lac_cnt2 got %0d want %0d", commit_cnt, c0 + 2);
        else npass++;
    endtask

    task automatic test_back_to_back;
        logic bad;
        bad = 1'b0;
        @(negedge clock_in);
        digit_sel = 2'd1;
        for (int i = 1; i <= 23; i++) begin
            @(posedge clock_in);
            #1;
            if (i >= 3 && anode !== 4'b1111) bad = 1'b1;
            if (i == 5) digit_sel = 2'd2;
        end
        ntot++;
        if (bad) $display("FAIL b2b_dark got an early anode want 1111 throughout");
        else npass++;
        @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b1011 || cathode !== 7'b0000010)
            $display("FAIL b2b_on got %b %b want 1011 0000010", anode, cathode);
        else npass++;
    endtask

    task automatic test_reset_mid;
        int c0;
        pulse_load(16'hFFFF, 4'b1111);
        @(negedge clock_in);
        #5 reset = 1'b1;
        #2;
        ntot++;
        if (anode !== 4'b1111 || cathode !== 7'b1111111 || commit !== 1'b0)
            $display("FAIL rmid got %b %b commit=%b want 1111 1111111 0",
                     anode, cathode, commit);
        else npass++;
        digit_sel = 2'd0;
        #3 reset = 1'b0;
        c0 = commit_cnt;
        drive_digit(2'd3);
        @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b0111 || cathode !== 7'b1000000 || dp_n !== 1'b1)
            $display("FAIL rmid_d3 got %b %b dp_n=%b want 0111 1000000 1",
                     anode, cathode, dp_n);
        else npass++;
        drive_digit(2'd0);
        @(posedge clock_in);
        #1;
        ntot++;
        if (anode !== 4'b1110 || cathode !== 7'b1000000 || dp_n !== 1'b1)
            $display("FAIL rmid_d0 got %b %b dp_n=%b want 1110 1000000 1",
                     anode, cathode, dp_n);
        else npass++;
        ntot++;
        if (commit_cnt !== c0) $display("FAIL rmid_commit got %0d want %0d", commit_cnt, c0);
        else npass++;
    endtask

    initial begin
        test_reset;
        test_scan_no_load;
        test_load_commit;
        test_lz;
        test_load_at_commit;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
# seg_display_driver

Downstream stage of the seven-segment digit-select counter: consumes its 2-bit digit select, drives the four active-low anodes, seven active-low cathodes and decimal point of the board display. Holds a double-buffered 16-bit hex value plus decimal points, committed only at a scan-frame boundary (tear-free). Inserts a programmable anti-ghosting blank interval on every digit change. Optional leading-zero suppression.

## Interface
- BLANK_CYCLES, 16, `clock_in` cycles all anodes are held off after each digit change; legal range 1..255.
- clock_in  input  1  system clock, nominally 25 MHz.
- reset  input  1  asynchronous, active-high reset.
- digit_sel  input  2  digit index from the mux counter; changes are asynchronous to `clock_in` edges and must be synchronized.
- data_in  input  16  hex value; nibble k drives digit k (digit 3 leftmost).
- dp_in  input  4  decimal-point enables, bit k for digit k, active-high.
- load  input  1  single-cycle strobe; captures `data_in`/`dp_in` into the shadow register.
- blank_lz  input  1  level; 1 = suppress leading zeros.
- anode  output  4  active-low digit enables; at most one bit low.
- cathode  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  output  1  active-low decimal point.
- commit  output  1  one-cycle pulse when the shadow is transferred to the display register.

## Operation
- Synchronizer: `digit_sel` passes through two flops (s1, s2); a third flop s3 holds the previous s2. A change is s2 != s3.
- Shadow: on `load`, shadow <= {`dp_in`,`data_in`}, pending <= 1.
- Commit: on a change where s2 == 0 and pending == 1: display <= shadow (value before this cycle's load), commit = 1. pending <= 0 unless `load` is also high in that cycle, in which case pending stays 1.
- Digit change cycle:
  - cur_digit <= s2.
  - blank_cnt <= BLANK_CYCLES.
  - anode <= 4'b1111.
  - cathode/dp_n <= decode of the nibble s2 from the display value in effect after this cycle's commit.
- Blank interval: while blank_cnt != 0, decrement. When blank_cnt == 1, anode <= ~(4'b0001 << cur_digit).
- A new change during the blank interval restarts it: anodes stay off, blank_cnt reloads.
- Decode, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking (`blank_lz`=1):
  - Digit 3 is blanked if nibble3 == 0.
  - Digit 2 is blanked if nibbles 3..2 == 0.
  - Digit 1 is blanked if nibbles 3..1 == 0.
  - Digit 0 is never blanked.
  - A blanked digit has cathode = 7'b1111111. `dp_n` still follows its dp bit.
- `blank_lz` is sampled at the digit change cycle only.

## Timing
- Reset values:
  - Outputs: anode 4'b1111, cathode 7'b1111111, dp_n 1, commit 0.
  - Internal: s1/s2/s3 0, shadow 0, display 0, pending 0, cur_digit 0, blank_cnt 0.
- The display stays dark after reset until the first `digit_sel` change is detected.
- Latency, `digit_sel` edge to change detection: 2 `clock_in` cycles.
- Latency, change detection to anode asserted: BLANK_CYCLES cycles. Cathode is valid BLANK_CYCLES cycles before its anode.
- `load` to visible: next synchronized 3->0 transition. `commit` pulses in the same cycle as that change-detection cycle.
- Reset mid-blank or mid-pending: all state returns to the reset values immediately; the pending load is discarded.
- blank_cnt is 8 bits wide and never wraps below 0.

## Test plan
- Reset, then cycle `digit_sel` 0,1,2,3 with no load:
  - anode goes 1110/1101/1011/0111, each BLANK_CYCLES+2 cycles after the edge.
  - cathode = 1000000 on every digit.
- `load` 16'h12AF, dp_in 4'b0100, while `digit_sel`=1:
  - Display is unchanged through digits 2 and 3.
  - `commit` pulses on the 3->0 detection.
  - Digit 0 shows F=0001110, digit 1 shows A=0001000, digit 2 shows 2=0100100 with dp_n=0, digit 3 shows 1=1111001.
- `blank_lz`=1 with value 16'h0050:
  - Digits 3 and 2 show cathode 1111111 with their anodes still asserted.
  - Digit 1 shows 5=0010010; digit 0 shows 0=1000000.
  - With value 16'h0000, only digit 0 is lit.
- `load` asserted in the exact cycle of a 3->0 commit:
  - The old shadow is displayed and commit=1.
  - pending stays 1; the new value commits at the next 3->0 transition.
- `digit_sel` toggles again 3 cycles into a BLANK_CYCLES=16 interval: anode stays 1111 for 16 cycles after the second detection, never enabling the interim digit.
- Reset asserted while pending=1 and an anode is on: anode=1111, cathode=1111111 and commit=0 with no clock; the discarded value never appears.
